fetch_sequencer: RTL and testbench

Control sequencer for the instruction fetch stage. Each cycle it picks the next-PC source (PC+4, branch, j, jr) and drives PC write enable, IF/ID write enable and IF/ID flush. It arbitrates redirect requests from later stages against load-use stalls and inserts a boot bubble and post-redirect flush bubbles. It also keeps saturating performance counters and a stall watchdog.

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage control sequencer: next-PC select, PC / IF-ID enables, IF-ID
// flush, redirect-vs-stall arbitration, boot and post-redirect bubbles,
// saturating performance counters and a sticky stall watchdog.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_BOOT  | single bubble cycle after reset release, inputs ignored
// S_RUN   | normal fetch, accepts redirects and stalls
// S_STALL | load-use stall in progress, watchdog counting
// S_FLUSH | post-redirect bubbles, wrong-path requests ignored
module fetch_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             jump_register_i,
  input  logic             stall_i,
  output logic [1:0]       pc_sel_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             hazard_error_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] redirect_count_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WD_LIMIT    = 8'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [7:0]       wd_q, wd_d;
  logic             hazard_q, hazard_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic redirect;
  logic stall_inc;
  logic redir_inc;

  assign redirect = branch_taken_i | jump_i | jump_register_i;

  // Mealy control outputs and next-state selection
  always_comb begin
    pc_sel_o     = 2'd0;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wd_d         = 8'd0;
    stall_inc    = 1'b0;
    redir_inc    = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        ifid_flush_o = 1'b1;
        state_d      = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (redirect) begin
          // A redirect comes from an older instruction, so it beats the stall.
          if (jump_register_i)  pc_sel_o = 2'd3;
          else if (jump_i)      pc_sel_o = 2'd2;
          else                  pc_sel_o = 2'd1;
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = 1'b1;
          redir_inc    = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_d = FLUSH_LOAD;
            state_d     = S_FLUSH;
          end else begin
            state_d = S_RUN;
          end
        end else if (stall_i) begin
          stall_inc = 1'b1;
          state_d   = S_STALL;
          if (state_q == S_STALL) begin
            wd_d = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
          end else begin
            wd_d = 8'd1;
          end
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          state_d      = S_RUN;
        end
      end
      S_FLUSH: begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b1;
        flush_cnt_d  = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Saturating counters and sticky watchdog flag next values
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    hazard_d    = hazard_q | (wd_d == WD_LIMIT);
    if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (redir_inc && (redir_cnt_q != CNT_MAX)) redir_cnt_d = redir_cnt_q + 1'b1;
  end

  // State, counter and flag registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_BOOT;
      flush_cnt_q <= 3'd0;
      wd_q        <= 8'd0;
      hazard_q    <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wd_q        <= wd_d;
      hazard_q    <= hazard_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign hazard_error_o   = hazard_q;
  assign stall_count_o    = stall_cnt_q;
  assign redirect_count_o = redir_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one instance with single-cycle flush,
// one with a 3-cycle flush, short watchdog limit and 3-bit counters.
module tb_fetch_sequencer;

  typedef struct {
    logic       br, j, jr, st;
    logic [1:0] sel;
    logic       pcw, ifw, fl;
    int         sc, rc;
    logic       hz;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, br1, j1, jr1, st1;
  logic [1:0] sel1;
  logic pcw1, ifw1, fl1, hz1;
  logic [15:0] sc1, rc1;

  logic rst3, br3, j3, jr3, st3;
  logic [1:0] sel3;
  logic pcw3, ifw3, fl3, hz3;
  logic [2:0] sc3, rc3;

  fetch_sequencer #(.FLUSH_CYCLES(1), .MAX_STALL(15), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst1),
    .branch_taken_i(br1), .jump_i(j1), .jump_register_i(jr1), .stall_i(st1),
    .pc_sel_o(sel1), .pc_write_o(pcw1), .ifid_write_o(ifw1), .ifid_flush_o(fl1),
    .hazard_error_o(hz1), .stall_count_o(sc1), .redirect_count_o(rc1)
  );

  fetch_sequencer #(.FLUSH_CYCLES(3), .MAX_STALL(4), .CNT_W(3)) dut3 (
    .clk_i(clk), .rst_i(rst3),
    .branch_taken_i(br3), .jump_i(j3), .jump_register_i(jr3), .stall_i(st3),
    .pc_sel_o(sel3), .pc_write_o(pcw3), .ifid_write_o(ifw3), .ifid_flush_o(fl3),
    .hazard_error_o(hz3), .stall_count_o(sc3), .redirect_count_o(rc3)
  );

  int checks   = 0;
  int failures = 0;

  vec_t v1[17];
  vec_t v3[10];

  function automatic vec_t mk(input logic br, j, jr, st, input logic [1:0] sel,
                              input logic pcw, ifw, fl, input int sc, rc,
                              input logic hz);
    vec_t v;
    v.br = br; v.j = j; v.jr = jr; v.st = st;
    v.sel = sel; v.pcw = pcw; v.ifw = ifw; v.fl = fl;
    v.sc = sc; v.rc = rc; v.hz = hz;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic br, j, jr, st);
    if (which == 1) begin
      br1 = br; j1 = j; jr1 = jr; st1 = st;
    end else begin
      br3 = br; j3 = j; jr3 = jr; st3 = st;
    end
  endtask

  task automatic check_vec(input int which, input string tag, input int idx, input vec_t v);
    int s, pw, iw, f, c, r, h;
    if (which == 1) begin
      s = int'(sel1); pw = int'(pcw1); iw = int'(ifw1); f = int'(fl1);
      c = int'(sc1); r = int'(rc1); h = int'(hz1);
    end else begin
      s = int'(sel3); pw = int'(pcw3); iw = int'(ifw3); f = int'(fl3);
      c = int'(sc3); r = int'(rc3); h = int'(hz3);
    end
    chk($sformatf("%s[%0d].pc_sel", tag, idx), s, int'(v.sel));
    chk($sformatf("%s[%0d].pc_write", tag, idx), pw, int'(v.pcw));
    chk($sformatf("%s[%0d].ifid_write", tag, idx), iw, int'(v.ifw));
    chk($sformatf("%s[%0d].ifid_flush", tag, idx), f, int'(v.fl));
    chk($sformatf("%s[%0d].stall_count", tag, idx), c, v.sc);
    chk($sformatf("%s[%0d].redirect_count", tag, idx), r, v.rc);
    chk($sformatf("%s[%0d].hazard", tag, idx), h, int'(v.hz));
  endtask

  // New cycle: inputs change 1 time unit after the rising edge, outputs are
  // sampled 3 units later, well before the next edge.
  task automatic cycle(input int which, input logic br, j, jr, st);
    @(posedge clk);
    #1;
    drive(which, br, j, jr, st);
    #3;
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    drive(1, 0, 0, 0, 0);
    drive(3, 0, 0, 0, 0);

    //           br j jr st sel pcw ifw fl sc rc hz
    v1[0]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);  // BOOT ignores jump
    v1[1]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    v1[2]  = mk(0, 1, 1, 0, 3, 1, 1, 1, 0, 0, 0);  // jr beats j
    v1[3]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);  // single squash only
    v1[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    v1[5]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    v1[6]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 0);
    v1[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 3, 1, 0);
    v1[8]  = mk(1, 0, 0, 1, 1, 1, 1, 1, 3, 1, 0);  // redirect beats stall
    v1[9]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 3, 2, 0);
    v1[10] = mk(0, 0, 0, 1, 0, 0, 0, 0, 3, 2, 0);
    v1[11] = mk(0, 1, 0, 1, 2, 1, 1, 1, 4, 2, 0);  // redirect out of STALL
    v1[12] = mk(0, 0, 0, 0, 0, 1, 1, 0, 4, 3, 0);
    v1[13] = mk(1, 0, 0, 0, 1, 1, 1, 1, 4, 3, 0);
    v1[14] = mk(0, 0, 0, 0, 0, 1, 1, 0, 4, 4, 0);
    v1[15] = mk(1, 1, 0, 0, 2, 1, 1, 1, 4, 4, 0);  // j beats branch
    v1[16] = mk(0, 0, 0, 0, 0, 1, 1, 0, 4, 5, 0);

    v3[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    v3[1]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    v3[2]  = mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
    v3[3]  = mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0);  // jump ignored in FLUSH
    v3[4]  = mk(0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0);  // jr and stall ignored
    v3[5]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    v3[6]  = mk(0, 0, 1, 0, 3, 1, 1, 1, 0, 1, 0);
    v3[7]  = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 2, 0);
    v3[8]  = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 2, 0);
    v3[9]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0);

    #2;
    check_vec(1, "reset1", 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    check_vec(3, "reset3", 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

    // ---- dut1 vector table ----
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      drive(1, v1[i].br, v1[i].j, v1[i].jr, v1[i].st);
      #3;
      check_vec(1, "v1", i, v1[i]);
    end

    // ---- dut1 watchdog: stall held 20 cycles, limit 15 ----
    for (int k = 1; k <= 20; k++) begin
      cycle(1, 0, 0, 0, 1);
      check_vec(1, "wd1", k, mk(0, 0, 0, 1, 0, 0, 0, 0, 4 + k - 1, 5, (k >= 16) ? 1'b1 : 1'b0));
    end
    cycle(1, 0, 0, 0, 0);
    check_vec(1, "wd1_release", 0, mk(0, 0, 0, 0, 0, 1, 1, 0, 24, 5, 1));
    cycle(1, 0, 0, 0, 0);
    check_vec(1, "wd1_sticky", 0, mk(0, 0, 0, 0, 0, 1, 1, 0, 24, 5, 1));

    // ---- dut1 reset pulse mid-STALL with StallCount=5 ----
    @(posedge clk);
    #1 rst1 = 1'b1;
    #3 check_vec(1, "rst_a", 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clk);
    #1 rst1 = 1'b0;
    drive(1, 0, 0, 0, 1);
    #3 check_vec(1, "boot_a", 0, mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 6; k++) begin
      cycle(1, 0, 0, 0, 1);
      check_vec(1, "pre_rst", k, mk(0, 0, 0, 1, 0, 0, 0, 0, k - 1, 0, 0));
    end
    #1 rst1 = 1'b1;
    #1 check_vec(1, "rst_mid", 0, mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clk);
    #1 rst1 = 1'b0;
    #3 check_vec(1, "boot_b", 0, mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    cycle(1, 0, 0, 0, 0);
    check_vec(1, "run_b", 0, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

    // ---- dut3 vector table ----
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      drive(3, v3[i].br, v3[i].j, v3[i].jr, v3[i].st);
      #3;
      check_vec(3, "v3", i, v3[i]);
    end

    // ---- dut3 redirect counter saturation at 7 ----
    for (int r = 0; r < 6; r++) begin
      cycle(3, 1, 0, 0, 0);
      check_vec(3, "sat_rd", r, mk(1, 0, 0, 0, 1, 1, 1, 1, 0, (2 + r > 7) ? 7 : 2 + r, 0));
      cycle(3, 0, 0, 0, 0);
      cycle(3, 0, 0, 0, 0);
    end
    cycle(3, 0, 0, 0, 0);
    check_vec(3, "sat_rd_end", 0, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 7, 0));

    // ---- dut3 stall counter saturation and watchdog limit 4 ----
    for (int k = 1; k <= 9; k++) begin
      cycle(3, 0, 0, 0, 1);
      check_vec(3, "sat_st", k, mk(0, 0, 0, 1, 0, 0, 0, 0, (k - 1 > 7) ? 7 : k - 1, 7,
                                   (k >= 5) ? 1'b1 : 1'b0));
    end
    cycle(3, 0, 0, 0, 0);
    check_vec(3, "sat_st_end", 0, mk(0, 0, 0, 0, 0, 1, 1, 0, 7, 7, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
